seg7_scan_reader: RTL and testbench

- Inverse of the team's hex-to-7-segment decoder.
- Watches a multiplexed, active-low 7-segment display bus (digit enables plus segment lines) and waits for each selection to hold stable.
- Encodes the segment pattern back to a hex nibble and stores it in a per-digit register.
- Used in the CPU bench and on-board self-check to read back what the display is actually showing.

---
 rtl/seg7_scan_reader.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_seg7_scan_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_reader.sv
// ---------------------------------------------------------------------------
// seg7_scan_reader
//
// Purpose:
//   Reads a multiplexed, active-low 7-segment display bus back into hex
//   nibbles. This is the inverse of the hex-to-7-segment decoder. A digit
//   selection must hold steady for STABLE_CYCLES samples before its segment
//   pattern is turned back into a nibble. That nibble is then stored in the
//   register for that digit.
//
// Parameters:
//   DIGITS        number of multiplexed digits (an_in width)
//   STABLE_CYCLES consecutive identical samples needed before a commit (>= 1)
//   CNT_W         settle counter width, 2**CNT_W >= STABLE_CYCLES
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   an_in        digit enables, active-low, bit i selects digit i
//   seg_in       segments, active-low, seg_in[6]=a ... seg_in[0]=g
//   hex_out      decoded nibbles, digit i at [4i+3:4i]
//   digit_valid  bit i set when digit i holds a committed hex value
//   upd_valid    one-cycle pulse on each recognised commit
//   upd_digit    index of the committed digit (valid with upd_valid)
//   upd_nibble   committed nibble (valid with upd_valid)
//   err          sticky flag: a stable, unrecognised pattern was seen
//   err_pattern  last unrecognised pattern
//
// Optional feature (macro SEG7_SCAN_DP_EN):
//   Adds the following ports:
//     dp_in   active-low decimal point
//     dp_out  per-digit decimal point, active-high
//   dp_in is sampled together with the segments and takes part in the
//   stability check. Without the macro, neither port exists.
// ---------------------------------------------------------------------------
module seg7_scan_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DIGITS-1:0]          an_in,
  input  logic [6:0]                 seg_in,
`ifdef SEG7_SCAN_DP_EN
  input  logic                       dp_in,
  output logic [DIGITS-1:0]          dp_out,
`endif
  output logic [4*DIGITS-1:0]        hex_out,
  output logic [DIGITS-1:0]          digit_valid,
  output logic                       upd_valid,
  output logic [$clog2(DIGITS)-1:0]  upd_digit,
  output logic [3:0]                 upd_nibble,
  output logic                       err,
  output logic [6:0]                 err_pattern
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  // Input sample registers
  logic [DIGITS-1:0] s_an_q, s_an_d;
  logic [6:0]        s_seg_q, s_seg_d;
`ifdef SEG7_SCAN_DP_EN
  logic              s_dp_q, s_dp_d;
  logic [DIGITS-1:0] dp_q, dp_d;
`endif

  // Control state
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Output registers
  logic [4*DIGITS-1:0] hex_q, hex_d;
  logic [DIGITS-1:0]   dv_q, dv_d;
  logic                upd_valid_q, upd_valid_d;
  logic [IDX_W-1:0]    upd_digit_q, upd_digit_d;
  logic [3:0]          upd_nibble_q, upd_nibble_d;
  logic                err_q, err_d;
  logic [6:0]          err_pattern_q, err_pattern_d;

  // Selection decode and commit strobes
  logic [DIGITS-1:0] an_low;
  logic              sel_legal;
  logic [IDX_W-1:0]  sel_idx;
  logic              changed;
  logic              commit;
  logic [4:0]        dec;

  // Segment pattern to {recognised, nibble}. Patterns that are not in the
  // table return recognised = 0. This includes the blank pattern; the commit
  // logic handles blank on its own.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b0000001: r = {1'b1, 4'h0};
      7'b1001111: r = {1'b1, 4'h1};
      7'b0010010: r = {1'b1, 4'h2};
      7'b0000110: r = {1'b1, 4'h3};
      7'b1001100: r = {1'b1, 4'h4};
      7'b0100100: r = {1'b1, 4'h5};
      7'b0100000: r = {1'b1, 4'h6};
      7'b0001111: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0000100: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b1100000: r = {1'b1, 4'hB};
      7'b0110001: r = {1'b1, 4'hC};
      7'b1000010: r = {1'b1, 4'hD};
      7'b0110000: r = {1'b1, 4'hE};
      7'b0111000: r = {1'b1, 4'hF};
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // The bus is captured every cycle without any further synchronisation.
  always_comb begin
    s_an_d  = an_in;
    s_seg_d = seg_in;
`ifdef SEG7_SCAN_DP_EN
    s_dp_d  = dp_in;
`endif
  end

  // The FSM compares the sample being captured on this edge with the sample
  // already held. A new selection therefore enters SETTLE on the same edge
  // that captures it. This is what makes a commit land STABLE_CYCLES+1 edges
  // after the bus settles.
  // A selection is legal only when exactly one enable is low. The check is
  // done on the inverted enables using the x & (x-1) one-hot test.
  always_comb begin
    an_low    = ~s_an_d;
    sel_legal = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);
    sel_idx   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (an_low[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
`ifdef SEG7_SCAN_DP_EN
    changed = ({s_an_d, s_seg_d, s_dp_d} != {s_an_q, s_seg_q, s_dp_q});
`else
    changed = ({s_an_d, s_seg_d} != {s_an_q, s_seg_q});
`endif
  end

  // Next-state logic.
  // An illegal selection always drops back to IDLE.
  // A legal change restarts settling. Only an unchanged SETTLE advances
  // the count. IDLE cannot see a legal unchanged sample, because leaving an
  // illegal selection always counts as a change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (!sel_legal) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (changed) begin
      state_d = SETTLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            commit  = 1'b1;
            state_d = HELD;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HELD:    state_d = HELD;
        default: state_d = IDLE;
      endcase
    end
  end

  // Commit handling. There are three cases:
  //   - A recognised pattern updates the digit and sends a pulse.
  //   - A blank pattern clears the digit.
  //   - Anything else only updates the error capture.
  // upd_digit and upd_nibble keep their last values between pulses.
  always_comb begin
    hex_d         = hex_q;
    dv_d          = dv_q;
    upd_valid_d   = 1'b0;
    upd_digit_d   = upd_digit_q;
    upd_nibble_d  = upd_nibble_q;
    err_d         = err_q;
    err_pattern_d = err_pattern_q;
`ifdef SEG7_SCAN_DP_EN
    dp_d          = dp_q;
`endif
    dec           = decode_seg(s_seg_q);
    if (commit) begin
      if (dec[4]) begin
        for (int d = 0; d < DIGITS; d++) begin
          if (IDX_W'(d) == sel_idx) begin
            hex_d[4*d +: 4] = dec[3:0];
            dv_d[d]         = 1'b1;
`ifdef SEG7_SCAN_DP_EN
            dp_d[d]         = ~s_dp_q;
`endif
          end
        end
        upd_valid_d  = 1'b1;
        upd_digit_d  = sel_idx;
        upd_nibble_d = dec[3:0];
      end else if (s_seg_q == SEG_BLANK) begin
        for (int d = 0; d < DIGITS; d++) begin
          if (IDX_W'(d) == sel_idx) begin
            hex_d[4*d +: 4] = 4'h0;
            dv_d[d]         = 1'b0;
`ifdef SEG7_SCAN_DP_EN
            dp_d[d]         = 1'b0;
`endif
          end
        end
      end else begin
        err_d         = 1'b1;
        err_pattern_d = s_seg_q;
      end
    end
  end

  // All state registers. The sample registers reset to "nothing selected,
  // all segments dark". As a result, a selection held through reset is seen
  // as a fresh change once reset releases.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_an_q        <= '1;
      s_seg_q       <= SEG_BLANK;
      state_q       <= IDLE;
      cnt_q         <= '0;
      hex_q         <= '0;
      dv_q          <= '0;
      upd_valid_q   <= 1'b0;
      upd_digit_q   <= '0;
      upd_nibble_q  <= '0;
      err_q         <= 1'b0;
      err_pattern_q <= '0;
`ifdef SEG7_SCAN_DP_EN
      s_dp_q        <= 1'b1;
      dp_q          <= '0;
`endif
    end else begin
      s_an_q        <= s_an_d;
      s_seg_q       <= s_seg_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hex_q         <= hex_d;
      dv_q          <= dv_d;
      upd_valid_q   <= upd_valid_d;
      upd_digit_q   <= upd_digit_d;
      upd_nibble_q  <= upd_nibble_d;
      err_q         <= err_d;
      err_pattern_q <= err_pattern_d;
`ifdef SEG7_SCAN_DP_EN
      s_dp_q        <= s_dp_d;
      dp_q          <= dp_d;
`endif
    end
  end

  assign hex_out     = hex_q;
  assign digit_valid = dv_q;
  assign upd_valid   = upd_valid_q;
  assign upd_digit   = upd_digit_q;
  assign upd_nibble  = upd_nibble_q;
  assign err         = err_q;
  assign err_pattern = err_pattern_q;
`ifdef SEG7_SCAN_DP_EN
  assign dp_out      = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_reader.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_reader
//
// Testbench for seg7_scan_reader in its default build (decimal point
// disabled).
//
// A reference model tracks how many consecutive identical bus samples have
// been seen, and commits a selection once that run reaches STABLE+1 edges.
// The bench drives directed scenarios first, then a randomised scan.
// ---------------------------------------------------------------------------
module tb_seg7_scan_reader;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an_in;
  logic [6:0]  seg_in;
  logic [15:0] hex_out;
  logic [3:0]  digit_valid;
  logic        upd_valid;
  logic [1:0]  upd_digit;
  logic [3:0]  upd_nibble;
  logic        err;
  logic [6:0]  err_pattern;

  seg7_scan_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .an_in       (an_in),
    .seg_in      (seg_in),
    .hex_out     (hex_out),
    .digit_valid (digit_valid),
    .upd_valid   (upd_valid),
    .upd_digit   (upd_digit),
    .upd_nibble  (upd_nibble),
    .err         (err),
    .err_pattern (err_pattern)
  );

  always #5 clk = ~clk;

  // Segment patterns for nibbles 0..F, in nibble order
  logic [6:0] pat [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int first_pulse = 0;

  // Reference model state
  logic [15:0] m_hex;
  logic [3:0]  m_dv;
  logic        m_upd_v;
  logic [1:0]  m_upd_d;
  logic [3:0]  m_upd_n;
  logic        m_err;
  logic [6:0]  m_err_pat;
  logic [3:0]  m_last_an;
  logic [6:0]  m_last_seg;
  int          m_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge, using the inputs present at that edge
  task automatic modelEdge();
    int idx;
    int nib;
    m_upd_v = 1'b0;
    if (reset) begin
      m_hex = '0; m_dv = '0; m_upd_d = '0; m_upd_n = '0;
      m_err = 1'b0; m_err_pat = '0;
      m_last_an = '1; m_last_seg = 7'h7F; m_run = 1;
    end else begin
      if (an_in == m_last_an && seg_in == m_last_seg) begin
        m_run++;
      end else begin
        m_run = 1;
        m_last_an = an_in;
        m_last_seg = seg_in;
      end
      if ($countones(~an_in) == 1 && m_run == STABLE + 1) begin
        idx = 0;
        for (int i = 0; i < DIGITS; i++) if (!an_in[i]) idx = i;
        nib = -1;
        for (int k = 0; k < 16; k++) if (pat[k] == seg_in) nib = k;
        if (nib >= 0) begin
          m_hex[4*idx +: 4] = 4'(nib);
          m_dv[idx] = 1'b1;
          m_upd_v = 1'b1;
          m_upd_d = 2'(idx);
          m_upd_n = 4'(nib);
        end else if (seg_in == 7'h7F) begin
          m_hex[4*idx +: 4] = 4'h0;
          m_dv[idx] = 1'b0;
        end else begin
          m_err = 1'b1;
          m_err_pat = seg_in;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".hex_out"}, 32'(hex_out), 32'(m_hex));
    check({tag, ".digit_valid"}, 32'(digit_valid), 32'(m_dv));
    check({tag, ".upd_valid"}, 32'(upd_valid), 32'(m_upd_v));
    check({tag, ".err"}, 32'(err), 32'(m_err));
    check({tag, ".err_pattern"}, 32'(err_pattern), 32'(m_err_pat));
    if (m_upd_v) begin
      check({tag, ".upd_digit"}, 32'(upd_digit), 32'(m_upd_d));
      check({tag, ".upd_nibble"}, 32'(upd_nibble), 32'(m_upd_n));
    end
  endtask

  // Hold one bus value for a number of cycles, checking against the model on
  // every cycle. first_pulse records the cycle (1-based) of the first upd_valid.
  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg,
                               input int cycles, input string tag);
    an_in = an;
    seg_in = seg;
    first_pulse = 0;
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput(tag);
      if (upd_valid === 1'b1) begin
        pulse_cnt++;
        if (first_pulse == 0) first_pulse = k;
      end
    end
  endtask

  initial begin
    int hold;
    int r;
    logic [3:0] an_r;
    logic [6:0] seg_r;

    reset = 1'b1;
    an_in = '1;
    seg_in = 7'h7F;

    // Reset values
    applyStimulus(4'b1111, 7'h7F, 2, "reset");
    check("reset.upd_digit", 32'(upd_digit), 32'd0);
    check("reset.upd_nibble", 32'(upd_nibble), 32'd0);
    check("reset.hex_out_const", 32'(hex_out), 32'h0);
    reset = 1'b0;

    // Digit 0 showing 2, single commit on edge 5
    pulse_cnt = 0;
    applyStimulus(4'b1110, 7'b0010010, 12, "t1");
    check("t1.pulses", pulse_cnt, 1);
    check("t1.latency", first_pulse, 5);
    check("t1.hex", 32'(hex_out), 32'h0002);
    check("t1.dv", 32'(digit_valid), 32'h1);

    // Digit 1: short-lived 1, then A held
    pulse_cnt = 0;
    applyStimulus(4'b1101, 7'b1001111, 2, "t2a");
    check("t2a.pulses", pulse_cnt, 0);
    applyStimulus(4'b1101, 7'b0001000, 10, "t2b");
    check("t2b.pulses", pulse_cnt, 1);
    check("t2b.latency", first_pulse, 5);
    check("t2b.hex_hi", 32'(hex_out[7:4]), 32'hA);

    // Two digits enabled: illegal, nothing commits
    pulse_cnt = 0;
    applyStimulus(4'b1100, 7'b0000000, 10, "t3");
    check("t3.pulses", pulse_cnt, 0);
    check("t3.hex", 32'(hex_out), 32'h00A2);
    check("t3.dv", 32'(digit_valid), 32'h3);

    // Unknown pattern on digit 2, then blank on digit 0
    applyStimulus(4'b1011, 7'b1111110, 8, "t4a");
    check("t4a.err", 32'(err), 32'd1);
    check("t4a.err_pattern", 32'(err_pattern), 32'h7E);
    check("t4a.dv2", 32'(digit_valid[2]), 32'd0);
    applyStimulus(4'b1110, 7'b1111111, 8, "t4b");
    check("t4b.dv0", 32'(digit_valid[0]), 32'd0);
    check("t4b.hex_lo", 32'(hex_out[3:0]), 32'h0);

    // Two scan rounds of 1,A,C,F
    pulse_cnt = 0;
    for (int round = 0; round < 2; round++) begin
      applyStimulus(4'b1110, pat[1], 8, "t5d0");
      applyStimulus(4'b1101, pat[10], 8, "t5d1");
      applyStimulus(4'b1011, pat[12], 8, "t5d2");
      applyStimulus(4'b0111, pat[15], 8, "t5d3");
    end
    check("t5.pulses", pulse_cnt, 8);
    check("t5.hex", 32'(hex_out), 32'hFCA1);
    check("t5.dv", 32'(digit_valid), 32'hF);

    // Digit 3 showing 7, interrupted by a one-cycle reset
    pulse_cnt = 0;
    applyStimulus(4'b0111, pat[7], 3, "t6a");
    check("t6a.pulses", pulse_cnt, 0);
    reset = 1'b1;
    applyStimulus(4'b0111, pat[7], 1, "t6rst");
    reset = 1'b0;
    applyStimulus(4'b0111, pat[7], 8, "t6b");
    check("t6b.pulses", pulse_cnt, 1);
    check("t6b.latency", first_pulse, 5);
    check("t6b.hex_hi", 32'(hex_out[15:12]), 32'h7);

    // Randomised scan against the model
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8) an_r = ~(4'b0001 << $urandom_range(0, 3));
      else an_r = 4'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7) seg_r = pat[$urandom_range(0, 15)];
      else if (r < 8) seg_r = 7'h7F;
      else seg_r = 7'($urandom);
      hold = $urandom_range(1, 9);
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        applyStimulus(an_r, seg_r, 1, "rnd_rst");
        reset = 1'b0;
      end
      applyStimulus(an_r, seg_r, hold, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
